// File: rtl/andor_arb_pkg.sv
// Shared types and constants for the round-robin AND/OR arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package andor_arb_pkg;

    localparam logic OP_AND = 1'b0;
    localparam logic OP_OR  = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    // Requester index width: at least one bit even for tiny configurations.
    function automatic int idw(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/andor_rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_grant, wrapping.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides whether the pick is used.
module andor_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    output logic               any_req,
    output logic [IDW-1:0]     grant_idx,
    output logic [NUM_REQ-1:0] grant_oh
);

    // Walk the offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        int idx;
        idx       = 0;
        any_req   = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (req[idx]) begin
                any_req       = 1'b1;
                grant_idx     = IDW'(idx);
                grant_oh      = '0;
                grant_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/andor_rr_arbiter.sv
// Round-robin shared AND/OR unit with a tagged, registered result port (optional ANDOR_ARB_BACK2BACK_EN).
// Latency: result valid one cycle after acceptance; 1 op/2 cycles, or 1 op/cycle with ANDOR_ARB_BACK2BACK_EN.
// Backpressure: result is held while res_ready is low; no request is accepted until it drains.
module andor_rr_arbiter
    import andor_arb_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  WIDTH   = 8,
    localparam int IDW     = idw(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_op,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic [IDW-1:0]           res_id
);

    state_t             state;
    logic [IDW-1:0]     last_grant;
    logic               any_req;
    logic [IDW-1:0]     grant_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic               can_grant;
    logic               take;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   op_res;

    andor_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .any_req    (any_req),
        .grant_idx  (grant_idx),
        .grant_oh   (grant_oh)
    );

    // Grant window: only when the result register is free (or draining this cycle) and not in reset.
    always_comb begin
`ifdef ANDOR_ARB_BACK2BACK_EN
        can_grant = !rst && ((state == ST_IDLE) || res_ready);
`else
        can_grant = !rst && (state == ST_IDLE);
`endif
        take      = can_grant && any_req;
        req_ready = take ? grant_oh : '0;
    end

    // Shared bitwise datapath on the picked requester's operands.
    always_comb begin
        op_a   = req_a[int'(grant_idx)*WIDTH +: WIDTH];
        op_b   = req_b[int'(grant_idx)*WIDTH +: WIDTH];
        op_res = op_a & op_b;
        case (req_op[grant_idx])
            OP_OR:   op_res = op_a | op_b;
            OP_AND:  op_res = op_a & op_b;
            default: op_res = op_a & op_b;
        endcase
    end

    // Control FSM and result register: load on grant, release on consumer handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_id     <= '0;
            last_grant <= IDW'(NUM_REQ - 1);
        end else if (take) begin
            state      <= ST_BUSY;
            res_valid  <= 1'b1;
            res_data   <= op_res;
            res_id     <= grant_idx;
            last_grant <= grant_idx;
        end else if ((state == ST_BUSY) && res_ready) begin
            state     <= ST_IDLE;
            res_valid <= 1'b0;
        end
    end

endmodule

// File: doc/andor_rr_arbiter.md
Name: andor_rr_arbiter

Overview:
- Shares one registered AND/OR logic unit between NUM_REQ requesters using round-robin arbitration.
- Each requester presents two WIDTH-bit operands and a 1-bit op select (0 = AND, 1 = OR) with valid/ready.
- The block grants one requester, computes `op ? (a|b) : (a&b)` bitwise, and holds the tagged result on a valid/ready output port until it is consumed.
- It sits between the gate-level logic datapath and any multi-client user of it.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- WIDTH, 8, operand/result width in bits; at least 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  bit i = requester i has an operation pending.
- req_ready  output  NUM_REQ  one-hot-or-zero; bit i = requester i's operation is accepted this cycle.
- req_a  input  NUM_REQ*WIDTH  operand A; requester i occupies slice [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  operand B; same slicing as req_a.
- req_op  input  NUM_REQ  per-requester op select; 0 = AND, 1 = OR.
- res_valid  output  1  result register holds an unconsumed result.
- res_ready  input  1  consumer accepts the result.
- res_data  output  WIDTH  computed result.
- res_id  output  IDW  index of the requester that produced res_data; IDW = max(1, $clog2(NUM_REQ)).

Behaviour:
- Reset (async assert, released synchronously to clk):
  - res_valid = 0, res_data = 0, res_id = 0, state = IDLE.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority after reset.
- States:
  - IDLE: no result held.
  - BUSY: result held, res_valid = 1.
- IDLE:
  - If any req_valid is set, select g = first set bit searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - req_ready[g] = 1 combinationally in the same cycle.
  - On the clock edge:
    - res_data <= req_op[g] ? (a_g | b_g) : (a_g & b_g)
    - res_id <= g
    - last_grant <= g
    - res_valid <= 1
    - state -> BUSY
  - If no req_valid is set, req_ready = 0 and the block stays in IDLE.
- BUSY:
  - req_ready = 0 (unless the optional feature is enabled); res_valid = 1.
  - res_data and res_id are stable until handshake.
  - When res_valid && res_ready: res_valid <= 0, state -> IDLE.
- Latency and throughput:
  - Request acceptance to res_valid is 1 cycle.
  - Base throughput is one operation per 2 cycles when the consumer is always ready.
- Fairness:
  - With all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,...
  - A requester waits at most NUM_REQ-1 grants.
- Requester protocol: once req_valid[i] is raised, it and req_a/req_b/req_op[i] stay stable until req_ready[i]. The arbiter does not check this; the bench asserts it.
- Boundary cases:
  - Single active requester: granted every opportunity.
  - Pointer wraps from NUM_REQ-1 to 0.
  - A requester newly valid in the grant cycle is eligible in that same cycle.
  - res_ready held low: the block stays in BUSY indefinitely with no loss.
  - rst asserted in BUSY: the pending result is discarded and the reset values above apply immediately.
  - req_valid bits are ignored while rst is high.
- Arithmetic: purely bitwise; no carry; width is exactly WIDTH.

Optional Feature:
- Macro: ANDOR_ARB_BACK2BACK_EN.
- Defined: in BUSY, when res_ready = 1, the arbiter also grants a new request in the same cycle.
  - The result register reloads and res_valid stays 1.
  - Throughput becomes one operation per cycle.
  - If no request is valid, the block returns to IDLE as usual.
- Undefined: base behaviour; req_ready is always 0 in BUSY.

Decomposition:
- Package andor_arb_pkg:
  - Op encoding constants OP_AND = 1'b0, OP_OR = 1'b1.
  - State enum {ST_IDLE, ST_BUSY}.
  - Helper function for IDW.
- Sub-module andor_rr_pick:
  - Combinational round-robin picker.
  - Inputs: req vector, last_grant.
  - Outputs: any_req, grant index, one-hot grant.
- The AND/OR datapath stays inline.

Test Plan:
- Reset, then only requester 2 valid with a = 8'hF0, b = 8'h3C, op = 0.
  - req_ready = 4'b0100 in that cycle.
  - Next cycle: res_valid = 1, res_data = 8'h30, res_id = 2.
- Requester 1 with a = 8'hA5, b = 8'h0F, op = 1 → res_data = 8'hAF, res_id = 1.
- All 4 requesters always valid and res_ready = 1 → res_id sequence 0,1,2,3,0,1 with a grant every 2 cycles (every cycle with ANDOR_ARB_BACK2BACK_EN).
- Hold res_ready = 0 for 10 cycles after a result → res_valid, res_data and res_id stable; req_ready = 0 throughout; then res_ready = 1 → next grant goes to last_grant+1.
- Assert rst while BUSY with res_data = 8'h30 → res_valid = 0, res_data = 0 immediately; after release, requester 0 wins first if valid.
- NUM_REQ = 2, WIDTH = 1: requester 1 only → granted repeatedly; pointer wrap 1→0→1 when both are valid.
